// File: rtl/priority_mux.sv
// priority_mux: registered non-preemptive priority arbiter steering the granted requester's data to one output.
module priority_mux #(
    parameter int N_PRIORITY_WIDTH = 3,
    parameter int N_SIGNAL_WIDTH   = 8,
    parameter int N_SIGNALS        = 8
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [N_PRIORITY_WIDTH*N_SIGNALS-1:0]  priorities_in,
    input  logic [N_SIGNAL_WIDTH*N_SIGNALS-1:0]    signals_in,
    output logic [N_SIGNAL_WIDTH-1:0]              signal_out,
    input  logic [N_SIGNALS-1:0]                   signal_req,
    output logic [N_SIGNALS-1:0]                   signal_ack,
    output logic                                   busy
);
    localparam int IW = $clog2(N_SIGNALS);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t                    state_q, state_d;
    logic [IW-1:0]             winner_q, winner_d, sel;
    logic [N_SIGNAL_WIDTH-1:0] out_q, out_d;
    logic [N_SIGNALS-1:0]      ack_q, ack_d;
    logic                      busy_q, busy_d;
    logic [N_PRIORITY_WIDTH-1:0] best;
    logic                      found, grant_now, hold;
    // strict '>' keeps the lowest index on a priority tie
    always_comb begin
        sel   = '0;
        best  = '0;
        found = 1'b0;
        for (int i = 0; i < N_SIGNALS; i++)
            if (signal_req[i] && (!found || priorities_in[i*N_PRIORITY_WIDTH +: N_PRIORITY_WIDTH] > best)) begin
                found = 1'b1;
                best  = priorities_in[i*N_PRIORITY_WIDTH +: N_PRIORITY_WIDTH];
                sel   = IW'(i);
            end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            winner_q <= '0;
            out_q    <= '0;
            ack_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            out_q    <= out_d;
            ack_q    <= ack_d;
            busy_q   <= busy_d;
        end
    end
    always_comb begin
        grant_now = (state_q == IDLE) && (|signal_req);
        hold      = (state_q == GRANT) && signal_req[winner_q];
        state_d   = (grant_now || hold) ? GRANT : IDLE;
        winner_d  = grant_now ? sel : winner_q;
    end
    always_comb begin
        out_d  = (grant_now || hold) ? signals_in[winner_d*N_SIGNAL_WIDTH +: N_SIGNAL_WIDTH] : out_q;
        ack_d  = grant_now ? ({{(N_SIGNALS-1){1'b0}}, 1'b1} << sel) : (hold ? ack_q : '0);
        busy_d = grant_now || hold;
    end
    assign signal_out = out_q;
    assign signal_ack = ack_q;
    assign busy       = busy_q;
endmodule

// File: tb/tb_priority_mux.sv
// tb_priority_mux: vector table plus hand sequences, expected outputs queued at drive time and checked after each edge.
module tb_priority_mux;
    localparam logic [23:0] PRI = {3'd0, 3'd1, 3'd1, 3'd6, 3'd6, 3'd0, 3'd0, 3'd7};
    localparam logic [63:0] SIG = {8'd10, 8'd20, 8'd30, 8'd40, 8'd41, 8'd42, 8'd43, 8'd44};
    typedef struct {
        logic        rst;
        logic [7:0]  req;
        logic [7:0]  ack;
        logic [7:0]  out;
        logic        busy;
    } vec_t;
    typedef struct {
        string       name;
        logic [7:0]  ack;
        logic [7:0]  out;
        logic        busy;
    } exp_t;
    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] pri;
    logic [63:0] sig;
    logic [7:0]  req, ack, out;
    logic        busy;
    int          n_cmp = 0;
    int          n_bad = 0;
    exp_t        sb[$];
    exp_t        e;
    vec_t        tbl[13];
    priority_mux dut (
        .clk(clk), .rst(rst), .priorities_in(pri), .signals_in(sig),
        .signal_out(out), .signal_req(req), .signal_ack(ack), .busy(busy)
    );
    always #5 clk = ~clk;
    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", n, act, want);
        end
    endtask
    task automatic drive(input string n, input logic r, input logic [7:0] rq,
                         input logic [7:0] a, input logic [7:0] o, input logic b);
        exp_t x;
        @(negedge clk);
        rst = r;
        req = rq;
        x.name = n; x.ack = a; x.out = o; x.busy = b;
        sb.push_back(x);
    endtask
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.name, "/ack"}, {24'd0, ack}, {24'd0, e.ack});
            chk({e.name, "/out"}, {24'd0, out}, {24'd0, e.out});
            chk({e.name, "/busy"}, {31'd0, busy}, {31'd0, e.busy});
            chk({e.name, "/onehot"}, {31'd0, $onehot0(ack)}, 32'd1);
        end
    end
    initial begin
        rst = 1'b1; req = '0; pri = PRI; sig = SIG;
        tbl[0]  = '{1'b1, 8'h00, 8'h00, 8'd0,  1'b0};
        tbl[1]  = '{1'b1, 8'hFF, 8'h00, 8'd0,  1'b0};
        tbl[2]  = '{1'b0, 8'hFF, 8'h01, 8'd44, 1'b1};
        tbl[3]  = '{1'b0, 8'hFF, 8'h01, 8'd44, 1'b1};
        tbl[4]  = '{1'b0, 8'h00, 8'h00, 8'd44, 1'b0};
        tbl[5]  = '{1'b0, 8'hFE, 8'h08, 8'd41, 1'b1};
        for (int i = 6; i < 11; i++) tbl[i] = '{1'b0, 8'hFF, 8'h08, 8'd41, 1'b1};
        tbl[11] = '{1'b0, 8'hF7, 8'h00, 8'd41, 1'b0};
        tbl[12] = '{1'b0, 8'hF7, 8'h01, 8'd44, 1'b1};
        for (int i = 0; i < 13; i++)
            drive($sformatf("vec%0d", i), tbl[i].rst, tbl[i].req, tbl[i].ack, tbl[i].out, tbl[i].busy);
        @(negedge clk); sig[7:0] = 8'd99; @(posedge clk);
        drive("track", 1'b0, 8'h01, 8'h01, 8'd99, 1'b1);
        drive("rel_keep", 1'b0, 8'h00, 8'h00, 8'd99, 1'b0);
        sig[7:0] = 8'd77;
        drive("idle_keep", 1'b0, 8'h00, 8'h00, 8'd99, 1'b0);
        sig[7:0] = 8'd55;
        drive("pri0_tie", 1'b0, 8'h06, 8'h02, 8'd43, 1'b1);
        drive("pri0_rel", 1'b0, 8'h00, 8'h00, 8'd43, 1'b0);
        drive("top_idx", 1'b0, 8'h80, 8'h80, 8'd10, 1'b1);
        drive("top_rel", 1'b0, 8'h00, 8'h00, 8'd10, 1'b0);
        drive("pre_rst", 1'b0, 8'h01, 8'h01, 8'd55, 1'b1);
        drive("rst_mid0", 1'b1, 8'h01, 8'h00, 8'd0, 1'b0);
        drive("rst_mid1", 1'b1, 8'h01, 8'h00, 8'd0, 1'b0);
        drive("regrant", 1'b0, 8'h01, 8'h01, 8'd55, 1'b1);
        drive("regr_rel", 1'b0, 8'h00, 8'h00, 8'd55, 1'b0);
        for (int i = 0; i < 10; i++) begin
            drive($sformatf("noreq%0d", i), 1'b0, 8'h00, 8'h00, 8'd55, 1'b0);
            pri = 24'($urandom);
        end
        repeat (3) @(posedge clk);
        #2;
        chk("sb_drain", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/priority_mux.md
# priority_mux

Registered N-way priority arbiter and data multiplexer. Each requester presents a data word, a priority and a request line. The block grants the highest-priority active requester, steers that requester's data to a single output, and holds the grant with a four-phase req/ack handshake until the requester releases it. It sits between several producers and one shared consumer or bus.

## Interface
- N_PRIORITY_WIDTH, default 3: bits per priority field.
- N_SIGNAL_WIDTH, default 8: bits per data word.
- N_SIGNALS, default 8: number of requesters; must be 2 or more.

Ports:
- clk  input  1  sole clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- priorities_in  input  N_PRIORITY_WIDTH*N_SIGNALS  priority of requester i at bits [i*N_PRIORITY_WIDTH +: N_PRIORITY_WIDTH].
- signals_in  input  N_SIGNAL_WIDTH*N_SIGNALS  data of requester i at bits [i*N_SIGNAL_WIDTH +: N_SIGNAL_WIDTH].
- signal_out  output  N_SIGNAL_WIDTH  registered data of the granted requester.
- signal_req  input  N_SIGNALS  bit i high means requester i wants the output.
- signal_ack  output  N_SIGNALS  registered grant; one-hot or all-zero.
- busy  output  1  high while a grant is held.

## Operation
- The FSM has two states: IDLE and GRANT. A registered winner index (clog2(N_SIGNALS) bits) holds the current grantee.
- Arbitration runs only in IDLE, over requesters with signal_req[i]=1.
  - The numerically largest priority wins.
  - On a priority tie, the lowest index wins.
  - Priority 0 is a valid priority, not "disabled".
- IDLE with signal_req != 0 at an edge:
  - winner <= selected index.
  - signal_ack <= one-hot(winner).
  - signal_out <= signals_in[winner].
  - busy <= 1.
  - Next state is GRANT.
- IDLE with signal_req == 0 at an edge: outputs hold; signal_ack = 0 and busy = 0.
- GRANT with signal_req[winner] = 1 at an edge:
  - signal_out <= signals_in[winner] every cycle, so data tracks the granted source with one cycle of latency.
  - The ack and busy outputs hold.
- GRANT with signal_req[winner] = 0 at an edge:
  - signal_ack <= 0 and busy <= 0.
  - signal_out keeps its last value.
  - Next state is IDLE.
- Non-preemptive. While in GRANT, other requests and all priority changes are ignored, including a higher-priority request arriving mid-grant.
- Other requesters' req bits are ignored in GRANT and are re-evaluated at the first IDLE edge.
- Requesters hold req until they see ack. A req that drops before it is granted is simply not considered.
- priorities_in is sampled only at the arbitration edge.

## Timing
- Reset (rst=1 at an edge) forces state IDLE, winner 0, signal_ack 0, busy 0 and signal_out 0. Reset overrides any other activity, including mid-GRANT.
- Grant latency: req sampled high at edge k in IDLE gives ack, busy and signal_out valid after edge k.
- Release latency: req of the grantee sampled low at edge m gives ack and busy low after edge m.
- Minimum gap: one IDLE cycle separates consecutive grants, so back-to-back grants occur at edge m+1 at the earliest.
- A single requester can therefore be re-granted every 2 cycles at most.
- Invariants:
  - busy == |signal_ack.
  - signal_ack is never multi-hot.
  - signal_ack never changes while busy, except on release or reset.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- **All-request arbitration.**
  - Stimulus: after reset, signal_req=8'hFF; priorities i7..i0 = {0,1,1,6,6,0,0,7}; signals i7..i0 = {10,20,30,40,41,42,43,44}.
  - Required: one edge later, signal_ack=8'b0000_0001, signal_out=44, busy=1.
- **Tie-break.**
  - Stimulus: same priorities and data, signal_req=8'b1111_1110.
  - Required: indices 3 and 4 tie at priority 6; signal_ack=8'b0000_1000, signal_out=41.
- **Non-preemption and release.**
  - Stimulus: grant index 3; then raise req0 (priority 7); hold 5 cycles; then drop req3.
  - Required: ack stays 8'h08 throughout the hold; ack 0 and busy 0 one edge after the drop; ack 8'h01 one edge later.
- **Data tracking.**
  - Stimulus: while index 0 is granted, change its data from 44 to 99.
  - Required: signal_out=99 one edge later.
  - Stimulus: after release, change the data again.
  - Required: signal_out keeps its last value.
- **Reset mid-grant.**
  - Stimulus: rst=1 for one edge while in GRANT.
  - Required: signal_ack=0, busy=0, signal_out=0.
  - Required: a re-grant occurs only after rst=0, at the next edge with req active.
- **No requests.**
  - Stimulus: signal_req=0 for 10 cycles with arbitrary priorities.
  - Required: signal_ack=0, busy=0, signal_out unchanged.
